button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//  Front-end for the century clock's mode/increase/decrease buttons.
//  Per instance: 2-flop synchronise one raw mechanical button, debounce it, and emit:
//   - single-cycle press/release pulses;
//   - optional auto-repeat step pulses while held.
//  step_pulse feeds mode_button / increase_button / decrease_button of the clock top.
//  Instantiated once per button.
// PARAMETERS
//  BTN_ACTIVE_LOW    1          1: raw pin low = pressed; 0: high = pressed
//  DEB_CYCLES        1_000_000  consecutive stable sync samples to accept a level (20 ms @ 50 MHz); >=2
//  REP_DELAY_CYCLES  25_000_000 hold time from accepted press to first repeat (500 ms); >=2
//  REP_PERIOD_CYCLES 5_000_000  interval between repeats (100 ms); >=2
//  REPEAT_EN         1          0: no repeats (mode button); 1: auto-repeat
// PORTS
//  clk           in   1   system clock
//  rst           in   1   synchronous, active-low reset
//  btn_in        in   1   raw asynchronous button pin
//  press_pulse   out  1   1 cycle on accepted press
//  repeat_pulse  out  1   1 cycle per auto-repeat
//  step_pulse    out  1   press_pulse | repeat_pulse
//  release_pulse out  1   1 cycle on accepted release
//  held          out  1   debounced pressed level
// BEHAVIOUR
//  - One clock; reset is synchronous and active-low (rst==0 sampled at clk posedge).
//  - Reset: all outputs 0, FSM=IDLE, counters 0, both sync flops loaded with the released level.
//  - Normalisation: pressed = BTN_ACTIVE_LOW ? ~btn_in : btn_in, then 2-flop sync -> s_prs.
//  - All outputs are registered; no combinational path from btn_in.
//  - Counters are sized $clog2(max cycle param); no wrap ever occurs, since every count is cleared on a state change.
//  - FSM:
//    IDLE: held=0. s_prs=1 -> PRESS_CHK, cnt=1.
//    PRESS_CHK: s_prs=0 -> IDLE (glitch rejected, no pulse).
//      cnt==DEB_CYCLES-1 and s_prs=1 -> HELD; press_pulse=1 next cycle. Else cnt++.
//    HELD: held=1, rcnt++ from 0.
//      REPEAT_EN and rcnt==REP_DELAY_CYCLES-1 -> REPEAT, repeat_pulse next cycle, rcnt=0.
//      s_prs=0 -> REL_CHK, cnt=1 (release has priority over a same-cycle repeat).
//    REPEAT: held=1. Every REP_PERIOD_CYCLES cycles one repeat_pulse. s_prs=0 -> REL_CHK (same priority rule).
//    REL_CHK: held stays 1, no repeats.
//      s_prs=1 -> HELD with rcnt=0 (release bounce: no new press_pulse; repeat delay restarts).
//      cnt==DEB_CYCLES-1 and s_prs=0 -> IDLE; release_pulse=1 next cycle, held=0 same cycle.
//  - Latency: n0 = first posedge capturing pressed into flop 1.
//    press_pulse is high in the cycle after posedge n0+DEB_CYCLES+1; held rises in the same cycle.
//  - Repeat timing: with E = posedge entering HELD:
//    first repeat_pulse after posedge E+REP_DELAY_CYCLES, then every REP_PERIOD_CYCLES.
//  - Pulses never overlap: press and repeat are mutually exclusive, so step_pulse is exactly 1 cycle.
//  - Reset mid-operation: returns to the reset state immediately; any pulse in flight is dropped.
//    A button still held after reset release produces one fresh press_pulse after full debounce.
// STRUCTURE
//  - Shared package/header (clock_defs): FSM state encodings (IDLE, PRESS_CHK, HELD, REPEAT, REL_CHK).
//    It also holds the 50 MHz cycle-count constants for 20 ms, 500 ms and 100 ms, shared with the fsm/control modules.
//  - One sub-module, btn_sync: parameterised reset value, 2-flop synchroniser.
//    The debounce/repeat FSM and counters stay in this module.
// TESTING (bench params: DEB=4, REP_DELAY=10, REP_PERIOD=3, BTN_ACTIVE_LOW=1)
//  1. Pin low from posedge 0, held -> press_pulse and step_pulse high 1 cycle after posedge 5; held=1 thereafter.
//  2. Pin low for 3 cycles, then high -> no pulse of any kind; held stays 0; FSM back in IDLE.
//  3. Hold 40 cycles, REPEAT_EN=1 ->
//     - repeat_pulse after posedges 15, 18, 21, ...;
//     - step_pulse count = 1 + repeats;
//     - after release: release_pulse once, held=0, 4+2 cycles after release edge.
//  4. Same as 3 with REPEAT_EN=0 -> exactly one step_pulse, zero repeat_pulse.
//  5. Release bounce (high 2 cycles, low 1, high stable) after press ->
//     - one press_pulse, one release_pulse, no second press_pulse;
//     - held stays 1 until release accepted.
//  6. rst=0 for 1 cycle while HELD (pin still low) ->
//     - next cycle all outputs 0;
//     - a new press_pulse appears DEB+2 cycles after rst returns to 1.

Source files
------------

// File: rtl/clock_defs_pkg.sv
// ============================================================================
//  Module      : clock_defs_pkg
//  Description : Shared definitions for the century clock front-end:
//                button FSM state encodings, 50 MHz cycle-count constants
//                and a counter-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clock_defs_pkg;

  // Cycle counts at 50 MHz
  localparam int unsigned DEB_20MS_CYCLES  = 1_000_000;
  localparam int unsigned REP_500MS_CYCLES = 25_000_000;
  localparam int unsigned REP_100MS_CYCLES = 5_000_000;

  // Debounce / auto-repeat FSM states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS_CHK = 3'd1,
    ST_HELD      = 3'd2,
    ST_REPEAT    = 3'd3,
    ST_REL_CHK   = 3'd4
  } btn_state_t;

  // Width able to hold (max cycle parameter - 1); never below one bit.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    int unsigned w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    w = $clog2(m);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage : clock_defs_pkg

`default_nettype wire

// File: rtl/button_conditioner_btn_sync.sv
// ============================================================================
//  Module      : btn_sync
//  Description : Two-flop synchroniser for one asynchronous input with a
//                parameterised reset level.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,      // synchronous, active-low
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous level; reset loads the idle level
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule : btn_sync

`default_nettype wire

// File: rtl/button_conditioner.sv
// ============================================================================
//  Module      : button_conditioner
//  Description : Synchronise, debounce and auto-repeat one mechanical button.
//                Emits registered press / repeat / step / release pulses and
//                the debounced held level.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_conditioner
  import clock_defs_pkg::*;
#(
  parameter bit          BTN_ACTIVE_LOW    = 1'b1,
  parameter int unsigned DEB_CYCLES        = DEB_20MS_CYCLES,
  parameter int unsigned REP_DELAY_CYCLES  = REP_500MS_CYCLES,
  parameter int unsigned REP_PERIOD_CYCLES = REP_100MS_CYCLES,
  parameter bit          REPEAT_EN         = 1'b1
) (
  input  logic clk,
  input  logic rst,            // synchronous, active-low
  input  logic btn_in,         // raw asynchronous pin
  output logic press_pulse,
  output logic repeat_pulse,
  output logic step_pulse,
  output logic release_pulse,
  output logic held
);

  localparam int unsigned CNT_W =
    cnt_width(DEB_CYCLES, REP_DELAY_CYCLES, REP_PERIOD_CYCLES);

  localparam logic [CNT_W-1:0] c_deb_last    = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_delay_last  = CNT_W'(REP_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_period_last = CNT_W'(REP_PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);

  logic             w_pressed;
  logic             w_s_prs;
  btn_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;     // debounce counter
  logic [CNT_W-1:0] r_rcnt;    // repeat delay / period counter
  logic             r_press;
  logic             r_repeat;
  logic             r_step;
  logic             r_release;
  logic             r_held;

  // Normalise polarity so that 1 always means pressed downstream
  assign w_pressed = BTN_ACTIVE_LOW ? ~btn_in : btn_in;

  btn_sync #(
    .RST_VAL (1'b0)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (w_pressed),
    .o_sync  (w_s_prs)
  );

  // Debounce / auto-repeat FSM with registered outputs; every state change
  // clears the counters it leaves behind so they can never wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_rcnt    <= '0;
      r_press   <= 1'b0;
      r_repeat  <= 1'b0;
      r_step    <= 1'b0;
      r_release <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_repeat  <= 1'b0;
      r_step    <= 1'b0;
      r_release <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_held <= 1'b0;
          r_rcnt <= '0;
          if (w_s_prs) begin
            r_state <= ST_PRESS_CHK;
            r_cnt   <= c_one;
          end else begin
            r_cnt   <= '0;
          end
        end

        ST_PRESS_CHK: begin
          if (!w_s_prs) begin
            // Glitch shorter than the debounce window: drop it silently
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == c_deb_last) begin
            r_state <= ST_HELD;
            r_cnt   <= '0;
            r_rcnt  <= '0;
            r_held  <= 1'b1;
            r_press <= 1'b1;
            r_step  <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + c_one;
          end
        end

        ST_HELD: begin
          r_held <= 1'b1;
          if (!w_s_prs) begin
            // Release wins over a repeat due in the same cycle
            r_state <= ST_REL_CHK;
            r_cnt   <= c_one;
            r_rcnt  <= '0;
          end else if (REPEAT_EN && (r_rcnt == c_delay_last)) begin
            r_state  <= ST_REPEAT;
            r_rcnt   <= '0;
            r_repeat <= 1'b1;
            r_step   <= 1'b1;
          end else if (REPEAT_EN) begin
            r_rcnt   <= r_rcnt + c_one;
          end
        end

        ST_REPEAT: begin
          r_held <= 1'b1;
          if (!w_s_prs) begin
            r_state <= ST_REL_CHK;
            r_cnt   <= c_one;
            r_rcnt  <= '0;
          end else if (r_rcnt == c_period_last) begin
            r_rcnt   <= '0;
            r_repeat <= 1'b1;
            r_step   <= 1'b1;
          end else begin
            r_rcnt   <= r_rcnt + c_one;
          end
        end

        ST_REL_CHK: begin
          if (w_s_prs) begin
            // Release bounce: back to held, repeat delay starts over
            r_state <= ST_HELD;
            r_cnt   <= '0;
            r_rcnt  <= '0;
            r_held  <= 1'b1;
          end else if (r_cnt == c_deb_last) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_held    <= 1'b0;
            r_release <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + c_one;
            r_held  <= 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_rcnt  <= '0;
          r_held  <= 1'b0;
        end
      endcase
    end
  end

  assign press_pulse   = r_press;
  assign repeat_pulse  = r_repeat;
  assign step_pulse    = r_step;
  assign release_pulse = r_release;
  assign held          = r_held;

endmodule : button_conditioner

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// ============================================================================
//  Module      : tb_button_conditioner
//  Description : Self-checking bench for button_conditioner. Two instances
//                (auto-repeat on / off) share the pin and reset; expected
//                pulse events are queued when stimulus is driven and checked
//                cycle by cycle against both instances.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_conditioner;

  localparam int DEB    = 4;
  localparam int DELAY  = 10;
  localparam int PERIOD = 3;

  localparam int K_PRESS = 0;
  localparam int K_REP   = 1;
  localparam int K_REL   = 2;
  localparam int K_RST   = 3;

  typedef struct {
    int         cyc;
    int         kind;
    logic [1:0] mask;   // bit0: repeat instance, bit1: no-repeat instance
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic btn;

  logic p0, r0, s0, rl0, h0;
  logic p1, r1, s1, rl1, h1;

  int   cyc       = -1;
  int   n_checks  = 0;
  int   n_errors  = 0;
  bit   mon_stop  = 1'b0;
  ev_t  sb[$];

  logic [2:0] m_exp [2];
  logic       exp_held [2];
  logic [4:0] m_want;
  logic [4:0] m_got;
  ev_t        m_ev;
  int         step_cnt [2];
  int         rep_cnt  [2];
  int         press_cnt[2];
  int         rel_cnt  [2];

  button_conditioner #(
    .BTN_ACTIVE_LOW    (1'b1),
    .DEB_CYCLES        (DEB),
    .REP_DELAY_CYCLES  (DELAY),
    .REP_PERIOD_CYCLES (PERIOD),
    .REPEAT_EN         (1'b1)
  ) dut_rep (
    .clk           (clk),
    .rst           (rst),
    .btn_in        (btn),
    .press_pulse   (p0),
    .repeat_pulse  (r0),
    .step_pulse    (s0),
    .release_pulse (rl0),
    .held          (h0)
  );

  button_conditioner #(
    .BTN_ACTIVE_LOW    (1'b1),
    .DEB_CYCLES        (DEB),
    .REP_DELAY_CYCLES  (DELAY),
    .REP_PERIOD_CYCLES (PERIOD),
    .REPEAT_EN         (1'b0)
  ) dut_nrp (
    .clk           (clk),
    .rst           (rst),
    .btn_in        (btn),
    .press_pulse   (p1),
    .repeat_pulse  (r1),
    .step_pulse    (s1),
    .release_pulse (rl1),
    .held          (h1)
  );

  always #5 clk = ~clk;

  // cyc = index of the most recent posedge
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int d = 0; d < 2; d++) begin
      exp_held[d]  = 1'b0;
      step_cnt[d]  = 0;
      rep_cnt[d]   = 0;
      press_cnt[d] = 0;
      rel_cnt[d]   = 0;
    end
  end

  // Scoreboard monitor: pop events due this cycle and compare both instances
  always @(negedge clk) begin
    if (cyc >= 0 && !mon_stop) begin
      for (int d = 0; d < 2; d++) m_exp[d] = 3'b000;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        m_ev = sb.pop_front();
        n_checks++;
        assert (m_ev.cyc == cyc) else begin
          n_errors++;
          $error("FAIL sb_event_missed: event cycle %0d, now %0d", m_ev.cyc, cyc);
        end
        for (int d = 0; d < 2; d++) begin
          if (m_ev.mask[d]) begin
            case (m_ev.kind)
              K_PRESS: begin m_exp[d][2] = 1'b1; exp_held[d] = 1'b1; end
              K_REP:   m_exp[d][1] = 1'b1;
              K_REL:   begin m_exp[d][0] = 1'b1; exp_held[d] = 1'b0; end
              default: exp_held[d] = 1'b0;
            endcase
          end
        end
      end
      for (int d = 0; d < 2; d++) begin
        m_want = {m_exp[d][2], m_exp[d][1], m_exp[d][2] | m_exp[d][1],
                  m_exp[d][0], exp_held[d]};
        m_got  = (d == 0) ? {p0, r0, s0, rl0, h0} : {p1, r1, s1, rl1, h1};
        n_checks++;
        assert (m_got === m_want) else begin
          n_errors++;
          $error("FAIL outputs cyc%0d dut%0d {press,rep,step,rel,held}: got %b expected %b",
                 cyc, d, m_got, m_want);
        end
        step_cnt[d]  += (m_got[2] === 1'b1) ? 1 : 0;
        rep_cnt[d]   += (m_got[3] === 1'b1) ? 1 : 0;
        press_cnt[d] += (m_got[4] === 1'b1) ? 1 : 0;
        rel_cnt[d]   += (m_got[1] === 1'b1) ? 1 : 0;
      end
    end
  end

  // Hard time limit
  initial begin
    #100000;
    n_errors++;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic push_ev(input int c, input int k, input logic [1:0] m);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    e.mask = m;
    sb.push_back(e);
  endtask

  // Press whose first sampling edge is n0, release edge n0+L (L >= DEB)
  task automatic push_hold_events(input int n0, input int L);
    int p;
    p = n0 + DEB + 1;
    push_ev(p, K_PRESS, 2'b11);
    for (int k = p + DELAY; k <= n0 + L + 1; k += PERIOD)
      push_ev(k, K_REP, 2'b01);
    push_ev(n0 + L + DEB + 1, K_REL, 2'b11);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_hold(input int L);
    int n0;
    @(negedge clk);
    n0 = cyc + 1;
    if (L >= DEB) push_hold_events(n0, L);
    btn = 1'b0;
    repeat (L) @(negedge clk);
    btn = 1'b1;
  endtask

  task automatic chk(input string tag, input int got, input int want);
    n_checks++;
    assert (got === want) else begin
      n_errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  int b_step[2], b_rep[2], b_press[2], b_rel[2];

  task automatic snap();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      b_step[d]  = step_cnt[d];
      b_rep[d]   = rep_cnt[d];
      b_press[d] = press_cnt[d];
      b_rel[d]   = rel_cnt[d];
    end
  endtask

  initial begin
    int n0;
    int r;
    int x;

    // Reset, pin released (high)
    rst = 1'b0;
    btn = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(5);

    // Long hold: press timing, repeats, release timing; no-repeat instance
    snap();
    press_hold(40);
    idle(12);
    @(posedge clk);
    // repeats at n0+15,18,...,39 -> 9
    chk("hold40_rep_repeats", rep_cnt[0] - b_rep[0], 9);
    chk("hold40_rep_steps", step_cnt[0] - b_step[0], 10);
    chk("hold40_nrp_repeats", rep_cnt[1] - b_rep[1], 0);
    chk("hold40_nrp_steps", step_cnt[1] - b_step[1], 1);
    chk("hold40_releases", rel_cnt[0] - b_rel[0], 1);

    // Glitch one cycle shorter than the debounce window
    snap();
    press_hold(DEB - 1);
    idle(12);
    @(posedge clk);
    chk("glitch_steps", step_cnt[0] - b_step[0], 0);
    chk("glitch_releases", rel_cnt[1] - b_rel[1], 0);

    // Short hold just at the debounce threshold
    press_hold(DEB);
    idle(12);

    // Release bounce: high 2, low 1, high stable
    snap();
    @(negedge clk);
    n0 = cyc + 1;
    push_ev(n0 + DEB + 1, K_PRESS, 2'b11);
    btn = 1'b0;
    repeat (8) @(negedge clk);
    r = n0 + 8;
    push_ev(r + 8, K_REL, 2'b11);
    btn = 1'b1;
    repeat (2) @(negedge clk);
    btn = 1'b0;
    @(negedge clk);
    btn = 1'b1;
    idle(14);
    @(posedge clk);
    chk("bounce_presses", press_cnt[0] - b_press[0], 1);
    chk("bounce_releases", rel_cnt[0] - b_rel[0], 1);

    // Reset pulse while held, pin kept low
    snap();
    @(negedge clk);
    n0 = cyc + 1;
    push_ev(n0 + DEB + 1, K_PRESS, 2'b11);
    btn = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b0;
    x = cyc + 1;
    push_ev(x, K_RST, 2'b11);
    @(negedge clk);
    rst = 1'b1;
    push_hold_events(x + 1, 20);
    repeat (20) @(negedge clk);
    btn = 1'b1;
    idle(12);
    @(posedge clk);
    chk("rst_presses", press_cnt[1] - b_press[1], 2);
    chk("rst_releases", rel_cnt[1] - b_rel[1], 1);
    chk("rst_repeats", rep_cnt[0] - b_rep[0], 3);

    chk("scoreboard_drained", sb.size(), 0);

    @(negedge clk);
    mon_stop = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_button_conditioner

`default_nettype wire
